// File: rtl/unorm_pkg.sv
// Shared types and helpers for the round-robin normalizer scheduler.
//   scale_cfg_t : per-requester (input, output) binary-point pair
//   rr_pick     : rotate-priority first-one search
package unorm_pkg;

   localparam int unsigned SCALE_WIDTH = 6;
   localparam int unsigned DEF_N_REQ   = 4;
   localparam int unsigned DEF_A_WIDTH = 32;
   localparam int unsigned DEF_F_WIDTH = 32;
   localparam int unsigned ID_WIDTH    = $clog2(DEF_N_REQ);

   // Upper bound on requesters the picker can scan.
   localparam int unsigned MAX_REQ     = 32;
   localparam int unsigned MAX_REQ_W   = 5;

   typedef struct packed {
      logic [SCALE_WIDTH-1:0] a_scale;
      logic [SCALE_WIDTH-1:0] f_scale;
   } scale_cfg_t;

   // First set bit of valid at or after ptr, wrapping modulo n; returns ptr when none set.
   function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input int unsigned ptr,
                                           input int unsigned n);
      int unsigned idx;
      int unsigned result;
      logic        found;
      result = ptr;
      found  = 1'b0;
      for (int unsigned k = 0; k < MAX_REQ; k++) begin
         if (k < n && !found) begin
            idx = (ptr + k) % n;
            if (valid[idx[MAX_REQ_W-1:0]]) begin
               result = idx;
               found  = 1'b1;
            end
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/unorm_rr_sched_if.sv
// Bundle between requesters / downstream and the scheduler.
//   cfg_*    : per-requester scale programming
//   req_*    : N_REQ valid/ready request lanes, operands packed by index
//   out_*    : registered result with requester id and overflow flag
interface unorm_rr_sched_if #(
   parameter int unsigned N_REQ   = unorm_pkg::DEF_N_REQ,
   parameter int unsigned A_WIDTH = unorm_pkg::DEF_A_WIDTH,
   parameter int unsigned F_WIDTH = unorm_pkg::DEF_F_WIDTH
);
   import unorm_pkg::*;

   localparam int unsigned ID_W = $clog2(N_REQ);

   logic                     cfg_we;
   logic [ID_W-1:0]          cfg_idx;
   logic [SCALE_WIDTH-1:0]   cfg_a_scale;
   logic [SCALE_WIDTH-1:0]   cfg_f_scale;
   logic [N_REQ-1:0]         req_valid;
   logic [N_REQ-1:0]         req_ready;
   logic [N_REQ*A_WIDTH-1:0] req_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [F_WIDTH-1:0]       out_data;
   logic [ID_W-1:0]          out_id;
   logic                     out_ovf;

   modport master (
      output cfg_we, cfg_idx, cfg_a_scale, cfg_f_scale, req_valid, req_data, out_ready,
      input  req_ready, out_valid, out_data, out_id, out_ovf
   );

   modport slave (
      input  cfg_we, cfg_idx, cfg_a_scale, cfg_f_scale, req_valid, req_data, out_ready,
      output req_ready, out_valid, out_data, out_id, out_ovf
   );

endinterface

// File: rtl/unorm_shift.sv
// Combinational runtime binary-point mover: f = a * 2^(f_scale - a_scale),
// truncated toward zero on right shifts, wrapped to F_WIDTH with ovf flagging lost high bits.
//   a, a_scale, f_scale : operand and its / the wanted fractional bit counts
//   f, ovf              : rescaled result and overflow indicator
module unorm_shift #(
   parameter int unsigned A_WIDTH     = 32,
   parameter int unsigned F_WIDTH     = 32,
   parameter int unsigned SCALE_WIDTH = 6
) (
   input  logic [A_WIDTH-1:0]     a,
   input  logic [SCALE_WIDTH-1:0] a_scale,
   input  logic [SCALE_WIDTH-1:0] f_scale,
   output logic [F_WIDTH-1:0]     f,
   output logic                   ovf
);

   localparam int unsigned DW = SCALE_WIDTH + 1;
   // Wide enough that a maximal left shift loses nothing before the overflow test.
   localparam int unsigned TW = A_WIDTH + (2 ** SCALE_WIDTH);

   logic [DW-1:0] d;
   logic [DW-1:0] sh;
   logic [TW-1:0] ext;
   logic [TW-1:0] t;

   // Signed difference in two's complement; its sign picks the shift direction.
   always_comb begin
      d   = {1'b0, f_scale} - {1'b0, a_scale};
      sh  = d[DW-1] ? (~d + DW'(1)) : d;
      ext = {{(TW-A_WIDTH){1'b0}}, a};
      t   = d[DW-1] ? (ext >> sh) : (ext << sh);
      f   = t[F_WIDTH-1:0];
      ovf = |t[TW-1:F_WIDTH];
   end

endmodule

// File: rtl/unorm_rr_sched.sv
// Round-robin scheduler sharing one runtime normalizer among N_REQ requesters.
//   clk, reset_l : clock, async active-low reset
//   bus          : config, request lanes and registered result (slave side)
module unorm_rr_sched
   import unorm_pkg::*;
#(
   parameter int unsigned N_REQ   = DEF_N_REQ,
   parameter int unsigned A_WIDTH = DEF_A_WIDTH,
   parameter int unsigned F_WIDTH = DEF_F_WIDTH
) (
   input logic               clk,
   input logic               reset_l,
   unorm_rr_sched_if.slave   bus
);

   localparam int unsigned ID_W = $clog2(N_REQ);

   scale_cfg_t         cfg_q [N_REQ];
   logic [ID_W-1:0]    ptr_q;
   logic               out_valid_q;
   logic [F_WIDTH-1:0] out_data_q;
   logic [ID_W-1:0]    out_id_q;
   logic               out_ovf_q;

   logic [ID_W-1:0]    grant_c;
   logic [ID_W-1:0]    ptr_next_c;
   logic               any_c;
   logic               free_c;
   logic               accept_c;
   logic [A_WIDTH-1:0] a_sel_c;
   scale_cfg_t         cfg_sel_c;
   logic [F_WIDTH-1:0] f_c;
   logic               ovf_c;

   // Arbitration and per-lane ready; independent of operand data.
   always_comb begin
      any_c         = |bus.req_valid;
      free_c        = !out_valid_q || bus.out_ready;
      accept_c      = any_c && free_c;
      grant_c       = ID_W'(rr_pick(MAX_REQ'(bus.req_valid), 32'(ptr_q), N_REQ));
      ptr_next_c    = (32'(grant_c) == N_REQ - 1) ? '0 : grant_c + ID_W'(1);
      bus.req_ready = '0;
      if (accept_c) bus.req_ready[grant_c] = 1'b1;
   end

   // Winner's operand and scales; scales come from registers so a same-cycle write is not seen.
   always_comb begin
      a_sel_c   = '0;
      cfg_sel_c = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (grant_c == ID_W'(i)) begin
            a_sel_c   = bus.req_data[i*A_WIDTH +: A_WIDTH];
            cfg_sel_c = cfg_q[i];
         end
      end
   end

   unorm_shift #(
      .A_WIDTH     (A_WIDTH),
      .F_WIDTH     (F_WIDTH),
      .SCALE_WIDTH (SCALE_WIDTH)
   ) u_shift (
      .a       (a_sel_c),
      .a_scale (cfg_sel_c.a_scale),
      .f_scale (cfg_sel_c.f_scale),
      .f       (f_c),
      .ovf     (ovf_c)
   );

   // Per-requester scale registers.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         for (int unsigned i = 0; i < N_REQ; i++) cfg_q[i] <= '0;
      end else if (bus.cfg_we) begin
         for (int unsigned i = 0; i < N_REQ; i++) begin
            if (bus.cfg_idx == ID_W'(i)) cfg_q[i] <= '{a_scale: bus.cfg_a_scale,
                                                       f_scale: bus.cfg_f_scale};
         end
      end
   end

   // Output stage and rr pointer; payload holds its value after a drain.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         ptr_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
         out_ovf_q   <= 1'b0;
      end else if (accept_c) begin
         ptr_q       <= ptr_next_c;
         out_valid_q <= 1'b1;
         out_data_q  <= f_c;
         out_id_q    <= grant_c;
         out_ovf_q   <= ovf_c;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_id    = out_id_q;
   assign bus.out_ovf   = out_ovf_q;

endmodule
